draw_bg_ctrl: RTL

Frame-synchronous scene controller for the background/character drawing chain. It runs the game state machine: title, race, player-1 win, player-2 win, draw. It also owns both character X positions. It turns asynchronous-in-frame button presses into at most one position step per frame, and changes every output only at the start of vertical blanking. Its outputs configure the end-screen background stage and the two character-drawing stages of the pipeline, so no visible frame is ever torn.

---
 rtl/draw_bg_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/draw_bg_ctrl.sv
// draw_bg_ctrl: frame-synchronous scene controller for the race game.
// Runs the title/play/win/draw state machine and owns both character X
// positions. Button presses are latched into sticky flags during the frame
// and consumed on the tick at the start of vertical blanking, so scene and
// positions only ever change between visible frames.
//
// Handshake note: there is no valid/ready pair here. frame_tick is a
// one-cycle strobe; scene, char1_x and char2_x are valid and stable from the
// cycle frame_tick is high until the next frame_tick.
module draw_bg_ctrl #(
   parameter int X_W        = 11,
   parameter int X_START    = 32,
   parameter int FINISH_X   = 736,
   parameter int STEP       = 8,
   parameter int END_FRAMES = 180
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vblnk,
   input  logic           start,
   input  logic           p1_btn,
   input  logic           p2_btn,
   output logic [2:0]     scene,
   output logic [X_W-1:0] char1_x,
   output logic [X_W-1:0] char2_x,
   output logic           frame_tick
);

   localparam logic [2:0] S_TITLE  = 3'd0;
   localparam logic [2:0] S_PLAY   = 3'd1;
   localparam logic [2:0] S_P1_WIN = 3'd2;
   localparam logic [2:0] S_P2_WIN = 3'd3;
   localparam logic [2:0] S_DRAW   = 3'd4;

   localparam logic [X_W-1:0] X_START_V  = X_W'(X_START);
   localparam logic [X_W-1:0] FINISH_V   = X_W'(FINISH_X);
   localparam logic [X_W:0]   FINISH_W   = (X_W+1)'(FINISH_X);
   localparam logic [X_W:0]   STEP_W     = (X_W+1)'(STEP);
   localparam logic [7:0]     END_LAST   = 8'(END_FRAMES - 1);

   // edge-detect history
   logic vblnk_q, start_q, p1_q, p2_q;
   // vblnk must be seen low once after reset before a rise can tick,
   // so a vblnk already high at reset release is ignored
   logic vblnk_armed;
   logic st_pend, p1_pend, p2_pend;
   logic [7:0] end_cnt;

   logic tick;
   logic start_rise, p1_rise, p2_rise;

   logic [X_W:0]   sum1, sum2;
   logic [X_W-1:0] step1, step2;
   logic [X_W-1:0] play1, play2;

   logic [2:0]     scene_n;
   logic [X_W-1:0] x1_n, x2_n;
   logic [7:0]     cnt_n;

   assign tick       = vblnk & ~vblnk_q & vblnk_armed;
   assign start_rise = start  & ~start_q;
   assign p1_rise    = p1_btn & ~p1_q;
   assign p2_rise    = p2_btn & ~p2_q;

   // saturating step, summed one bit wider so it can never wrap
   always_comb begin
      sum1  = {1'b0, char1_x} + STEP_W;
      sum2  = {1'b0, char2_x} + STEP_W;
      step1 = (sum1 >= FINISH_W) ? FINISH_V : sum1[X_W-1:0];
      step2 = (sum2 >= FINISH_W) ? FINISH_V : sum2[X_W-1:0];
      play1 = p1_pend ? step1 : char1_x;
      play2 = p2_pend ? step2 : char2_x;
   end

   // next scene / positions / end counter, applied only on a tick
   always_comb begin
      scene_n = scene;
      x1_n    = char1_x;
      x2_n    = char2_x;
      cnt_n   = end_cnt;
      case (scene)
         S_TITLE: begin
            x1_n = X_START_V;
            x2_n = X_START_V;
            if (st_pend) scene_n = S_PLAY;
         end
         S_PLAY: begin
            x1_n = play1;
            x2_n = play2;
            cnt_n = 8'd0;
            if ((play1 == FINISH_V) && (play2 == FINISH_V)) scene_n = S_DRAW;
            else if (play1 == FINISH_V)                     scene_n = S_P1_WIN;
            else if (play2 == FINISH_V)                     scene_n = S_P2_WIN;
         end
         S_P1_WIN, S_P2_WIN, S_DRAW: begin
            if (end_cnt == END_LAST) begin
               scene_n = S_TITLE;
               cnt_n   = 8'd0;
               x1_n    = X_START_V;
               x2_n    = X_START_V;
            end else begin
               cnt_n = end_cnt + 8'd1;
            end
         end
         default: begin
            scene_n = S_TITLE;
            cnt_n   = 8'd0;
            x1_n    = X_START_V;
            x2_n    = X_START_V;
         end
      endcase
   end

   // edge history and arming of the vblank edge detector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_q     <= 1'b0;
         start_q     <= 1'b0;
         p1_q        <= 1'b0;
         p2_q        <= 1'b0;
         vblnk_armed <= 1'b0;
      end else begin
         vblnk_q <= vblnk;
         start_q <= start;
         p1_q    <= p1_btn;
         p2_q    <= p2_btn;
         if (!vblnk) vblnk_armed <= 1'b1;
      end
   end

   // sticky press flags: a new press wins over the tick clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_pend <= 1'b0;
         p1_pend <= 1'b0;
         p2_pend <= 1'b0;
      end else begin
         if (start_rise)  st_pend <= 1'b1;
         else if (tick)   st_pend <= 1'b0;
         if (p1_rise)     p1_pend <= 1'b1;
         else if (tick)   p1_pend <= 1'b0;
         if (p2_rise)     p2_pend <= 1'b1;
         else if (tick)   p2_pend <= 1'b0;
      end
   end

   // frame-gated scene, positions and end-screen counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scene      <= S_TITLE;
         char1_x    <= X_START_V;
         char2_x    <= X_START_V;
         end_cnt    <= 8'd0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= tick;
         if (tick) begin
            scene   <= scene_n;
            char1_x <= x1_n;
            char2_x <= x2_n;
            end_cnt <= cnt_n;
         end
      end
   end

endmodule
